// File: rtl/dmem_lsu_arb.sv
// Two-port load/store sequencer in front of the 32-word byte-masked data memory.
// Port 0 (core LSU) wins by default; port 1 (debug/loader) is forced through
// after STARVE_LIMIT consecutive port-0 grants taken while it was waiting.
// One access is in flight at a time:
//   IDLE -> ISSUE -> RESP  for legal requests
//   IDLE -> ERR            for misaligned or illegal-size requests
module dmem_lsu_arb #(
  parameter int ADDR_W       = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_uns,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_uns,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              resp_valid,
  output logic              resp_port,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_wren,
  output logic              mem_is_load,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-3:0] mem_r_addr,
  output logic [ADDR_W-3:0] mem_w_addr,
  output logic [31:0]       mem_w_data,
  input  logic [31:0]       mem_r_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_ERR} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     starve_cnt;
  logic              starved, idle;

  logic              sel_we, sel_uns, sel_legal;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  logic              rq_we, rq_uns, rq_port;
  logic [1:0]        rq_size;
  logic [ADDR_W-1:0] rq_addr;
  logic [31:0]       rq_wdata;

  logic [7:0]        ld_b;
  logic [15:0]       ld_h;

  // Grants are gated by rst so every output reads 0 while reset is held.
  assign idle    = (state == S_IDLE) && !rst;
  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  // Arbitration: port 0 by default, port 1 when port 0 is quiet or starvation is hit.
  always_comb begin
    p0_gnt = idle && p0_req && !(p1_req && starved);
    p1_gnt = idle && p1_req && (!p0_req || starved);
  end

  // Mux the winning request and classify its alignment.
  always_comb begin
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_uns   = p1_gnt ? p1_uns   : p0_uns;
    sel_size  = p1_gnt ? p1_size  : p0_size;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    case (sel_size)
      2'b00:   sel_legal = 1'b1;
      2'b01:   sel_legal = !sel_addr[0];
      2'b10:   sel_legal = (sel_addr[1:0] == 2'b00);
      default: sel_legal = 1'b0;
    endcase
  end

  // Sequencer next state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (p0_gnt || p1_gnt) state_nx = sel_legal ? S_ISSUE : S_ERR;
      S_ISSUE: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latch the granted request so the requester is free to move on next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_we    <= 1'b0;
      rq_uns   <= 1'b0;
      rq_port  <= 1'b0;
      rq_size  <= 2'b00;
      rq_addr  <= '0;
      rq_wdata <= '0;
    end else if (p0_gnt || p1_gnt) begin
      rq_we    <= sel_we;
      rq_uns   <= sel_uns;
      rq_port  <= p1_gnt;
      rq_size  <= sel_size;
      rq_addr  <= sel_addr;
      rq_wdata <= sel_wdata;
    end
  end

  // Starvation counter: counts port-0 wins over a waiting port 1, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              starve_cnt <= '0;
    else if (p1_gnt)                      starve_cnt <= '0;
    else if (p0_gnt && p1_req) begin
      if (!starved)                       starve_cnt <= starve_cnt + 1'b1;
    end else if ((state == S_IDLE) && !p1_req) starve_cnt <= '0;
  end

  // Memory side: strobes only in ISSUE; address and data simply follow the latch.
  always_comb begin
    mem_wren    = (state == S_ISSUE) && rq_we;
    mem_is_load = (state == S_ISSUE) && !rq_we;
    mem_r_addr  = rq_addr[ADDR_W-1:2];
    mem_w_addr  = rq_addr[ADDR_W-1:2];
    mem_mask    = 4'b0000;
    mem_w_data  = rq_wdata;
    case (rq_size)
      2'b00:   mem_w_data = {4{rq_wdata[7:0]}};
      2'b01:   mem_w_data = {2{rq_wdata[15:0]}};
      default: mem_w_data = rq_wdata;
    endcase
    if (mem_wren) begin
      case (rq_size)
        2'b00:   mem_mask = 4'b0001 << rq_addr[1:0];
        2'b01:   mem_mask = rq_addr[1] ? 4'b1100 : 4'b0011;
        default: mem_mask = 4'b1111;
      endcase
    end
  end

  // Response: lane select and extension of the registered memory read data.
  always_comb begin
    resp_valid = (state == S_RESP) || (state == S_ERR);
    resp_err   = (state == S_ERR);
    resp_port  = resp_valid && rq_port;
    resp_rdata = 32'd0;
    case (rq_addr[1:0])
      2'd0:    ld_b = mem_r_data[7:0];
      2'd1:    ld_b = mem_r_data[15:8];
      2'd2:    ld_b = mem_r_data[23:16];
      default: ld_b = mem_r_data[31:24];
    endcase
    ld_h = rq_addr[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    if ((state == S_RESP) && !rq_we) begin
      case (rq_size)
        2'b00:   resp_rdata = {{24{!rq_uns && ld_b[7]}}, ld_b};
        2'b01:   resp_rdata = {{16{!rq_uns && ld_h[15]}}, ld_h};
        default: resp_rdata = mem_r_data;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_arb.sv
// Bench for dmem_lsu_arb: byte-array reference model, directed scenarios and
// a randomized two-port phase, all compared cycle by cycle.
module tb_dmem_lsu_arb;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       r_req, r_we, r_uns;
  logic [1:0][1:0]  r_size;
  logic [1:0][6:0]  r_addr;
  logic [1:0][31:0] r_wdata;

  logic p0_gnt, p1_gnt, resp_valid, resp_port, resp_err, mem_wren, mem_is_load;
  logic [31:0] resp_rdata, mem_w_data;
  logic [3:0]  mem_mask;
  logic [4:0]  mem_r_addr, mem_w_addr;
  logic [31:0] mem_r_data = '0;

  dmem_lsu_arb #(.ADDR_W(7), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .p0_req(r_req[0]), .p0_we(r_we[0]), .p0_size(r_size[0]), .p0_uns(r_uns[0]),
    .p0_addr(r_addr[0]), .p0_wdata(r_wdata[0]), .p0_gnt(p0_gnt),
    .p1_req(r_req[1]), .p1_we(r_we[1]), .p1_size(r_size[1]), .p1_uns(r_uns[1]),
    .p1_addr(r_addr[1]), .p1_wdata(r_wdata[1]), .p1_gnt(p1_gnt),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_wren(mem_wren), .mem_is_load(mem_is_load),
    .mem_mask(mem_mask), .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // Byte-masked memory with registered read, driven by the DUT.
  logic [31:0] bmem [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) bmem[mem_w_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
    if (mem_is_load) mem_r_data <= bmem[mem_r_addr];
  end

  // Reference model state.
  logic [7:0] mb [128] = '{default: 8'd0};
  int cyc = 0, free_t = 0, iss_t = -1, resp_t = -1, starve = 0;
  logic e_we, e_port, e_err;
  logic [3:0] e_mask;
  logic [4:0] e_waddr;
  logic [31:0] e_wdata, e_rdata;
  logic [1:0] got_gnt = '0;

  // Observations used by the literal checks.
  logic [3:0] last_mask;
  logic [4:0] last_waddr;
  logic [31:0] last_wdata, last_rdata;
  logic last_err;
  int obs_gnt_cyc, obs_resp_cyc, mem_pulses = 0;
  int gnt_seq[$];

  int vecs = 0, errs = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic legal(logic [1:0] s, logic [6:0] a);
    return (s != 2'd3) && !(s == 2'd1 && a[0]) && !(s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  // Model a granted request: byte-array memory, spec-level mask/data/extension.
  task automatic launch(int p);
    int nb;
    logic [6:0] a;
    logic [31:0] v;
    a = r_addr[p];
    e_port = 1'(p);
    e_we = r_we[p];
    if (!legal(r_size[p], a)) begin
      e_err = 1'b1; e_rdata = 32'd0; iss_t = -1; resp_t = cyc + 1; free_t = cyc + 2;
    end else begin
      e_err = 1'b0; iss_t = cyc + 1; resp_t = cyc + 2; free_t = cyc + 3;
      nb = 1 << r_size[p];
      e_mask = 4'(((1 << nb) - 1) << a[1:0]);
      e_waddr = a[6:2];
      e_wdata = (nb == 1) ? {4{r_wdata[p][7:0]}} : (nb == 2) ? {2{r_wdata[p][15:0]}} : r_wdata[p];
      v = 32'd0;
      for (int i = 0; i < nb; i++) begin
        if (r_we[p]) mb[int'(a) + i] = r_wdata[p][8*i +: 8];
        else v[8*i +: 8] = mb[int'(a) + i];
      end
      if (!r_uns[p] && nb == 1 && v[7])  v[31:8]  = '1;
      if (!r_uns[p] && nb == 2 && v[15]) v[31:16] = '1;
      e_rdata = r_we[p] ? 32'd0 : v;
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  task automatic check_cycle();
    logic idle, eg0, eg1, ev;
    if (p0_gnt || p1_gnt) begin obs_gnt_cyc = cyc; gnt_seq.push_back(p1_gnt ? 1 : 0); end
    if (mem_wren || mem_is_load) begin
      mem_pulses++; last_mask = mem_mask; last_waddr = mem_w_addr; last_wdata = mem_w_data;
    end
    if (resp_valid) begin obs_resp_cyc = cyc; last_rdata = resp_rdata; last_err = resp_err; end
    if (rst) begin
      cmp("rst_gnt", {p1_gnt, p0_gnt}, 0);
      cmp("rst_memctl", {mem_wren, mem_is_load, mem_mask}, 0);
      cmp("rst_addr", {mem_r_addr, mem_w_addr}, 0);
      cmp("rst_wdata", mem_w_data, 0);
      cmp("rst_resp", {resp_valid, resp_port, resp_err}, 0);
      cmp("rst_rdata", resp_rdata, 0);
      iss_t = -1; resp_t = -1; free_t = cyc + 1; starve = 0;
    end else begin
      idle = (cyc >= free_t);
      eg0 = idle && r_req[0] && !(r_req[1] && starve == LIM);
      eg1 = idle && r_req[1] && !eg0;
      cmp("p0_gnt", p0_gnt, eg0);
      cmp("p1_gnt", p1_gnt, eg1);
      if (cyc == iss_t) begin
        cmp("mem_wren", mem_wren, e_we);
        cmp("mem_is_load", mem_is_load, !e_we);
        cmp("mem_mask", mem_mask, e_we ? e_mask : 4'd0);
        cmp("mem_r_addr", mem_r_addr, e_waddr);
        cmp("mem_w_addr", mem_w_addr, e_waddr);
        if (e_we) cmp("mem_w_data", mem_w_data, e_wdata);
      end else begin
        cmp("mem_quiet", {mem_wren, mem_is_load, mem_mask}, 0);
      end
      ev = (cyc == resp_t);
      cmp("resp_valid", resp_valid, ev);
      if (ev) begin
        cmp("resp_port", resp_port, e_port);
        cmp("resp_err", resp_err, e_err);
        cmp("resp_rdata", resp_rdata, e_rdata);
      end else begin
        cmp("resp_err_idle", resp_err, 0);
      end
      if (eg0 || eg1) begin
        launch(eg1 ? 1 : 0);
        got_gnt[eg1 ? 1 : 0] = 1'b1;
      end
      if (eg1) starve = 0;
      else if (eg0 && r_req[1]) starve = (starve < LIM) ? starve + 1 : LIM;
      else if (idle && !r_req[1]) starve = 0;
    end
    cyc++;
  endtask

  // One cycle: compare at negedge, return just after the next posedge.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int p, logic we, logic [1:0] s, logic u, logic [6:0] a, logic [31:0] d);
    r_we[p] = we; r_size[p] = s; r_uns[p] = u; r_addr[p] = a; r_wdata[p] = d;
  endtask

  // Issue one request on port p, wait (bounded) for the grant, then let it finish.
  task automatic do_op(int p, logic we, logic [1:0] s, logic u, logic [6:0] a, logic [31:0] d);
    int n;
    set_req(p, we, s, u, a, d);
    r_req[p] = 1'b1;
    got_gnt[p] = 1'b0;
    n = 0;
    while (!got_gnt[p] && n < 20) begin step(); n++; end
    if (!got_gnt[p]) cmp("gnt_timeout", 0, 1);
    r_req[p] = 1'b0;
    got_gnt[p] = 1'b0;
    repeat (3) step();
  endtask

  task automatic rand_req(int p);
    logic [1:0] s;
    logic [6:0] a;
    s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a = 7'($urandom_range(0, 127));
    if ($urandom_range(0, 4) != 0) begin
      if (s == 2'd1) a[0] = 1'b0;
      if (s == 2'd2) a[1:0] = 2'b00;
    end
    set_req(p, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    int pulses0, n;
    rst = 1'b1;
    r_req = '0; r_we = '0; r_uns = '0; r_size = '0; r_addr = '0; r_wdata = '0;
    #1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Word store then load, with latency.
    do_op(0, 1, 2'd2, 0, 7'h08, 32'hDEADBEEF);
    cmp("sw_mask", last_mask, 4'b1111);
    cmp("sw_waddr", last_waddr, 5'd2);
    do_op(0, 0, 2'd2, 0, 7'h08, 32'd0);
    cmp("lw_data", last_rdata, 32'hDEADBEEF);
    cmp("lw_latency", obs_resp_cyc - obs_gnt_cyc, 2);

    // Byte lanes and extension.
    do_op(0, 1, 2'd0, 0, 7'h0B, 32'h00000080);
    cmp("sb_mask", last_mask, 4'b1000);
    cmp("sb_wdata", last_wdata, 32'h80808080);
    do_op(0, 0, 2'd0, 0, 7'h0B, 32'd0);
    cmp("lb_data", last_rdata, 32'hFFFFFF80);
    do_op(0, 0, 2'd0, 1, 7'h0B, 32'd0);
    cmp("lbu_data", last_rdata, 32'h00000080);
    do_op(0, 0, 2'd1, 0, 7'h0A, 32'd0);
    cmp("lh_data", last_rdata, 32'hFFFF80AD);

    // Misaligned word and illegal size: error one cycle after grant, no memory strobe.
    pulses0 = mem_pulses;
    do_op(0, 0, 2'd2, 0, 7'h06, 32'd0);
    cmp("mis_err", last_err, 1);
    cmp("mis_latency", obs_resp_cyc - obs_gnt_cyc, 1);
    do_op(1, 1, 2'd3, 0, 7'h00, 32'h12345678);
    cmp("sz3_err", last_err, 1);
    cmp("err_no_mem", mem_pulses - pulses0, 0);

    // Half store and unsigned half load from port 1.
    do_op(1, 1, 2'd1, 0, 7'h12, 32'h00001234);
    cmp("sh_mask", last_mask, 4'b1100);
    cmp("sh_wdata", last_wdata, 32'h12341234);
    do_op(1, 0, 2'd1, 1, 7'h12, 32'd0);
    cmp("lhu_data", last_rdata, 32'h00001234);

    // Starvation: both ports requesting continuously.
    gnt_seq.delete();
    set_req(0, 0, 2'd2, 0, 7'h08, 32'd0);
    set_req(1, 0, 2'd1, 1, 7'h12, 32'd0);
    r_req = 2'b11;
    n = 0;
    while (gnt_seq.size() < 10 && n < 60) begin step(); n++; end
    r_req = 2'b00;
    got_gnt = '0;
    repeat (3) step();
    cmp("starve_cnt", gnt_seq.size(), 10);
    for (int i = 0; i < 10 && i < gnt_seq.size(); i++)
      cmp("starve_seq", gnt_seq[i], (i % 5 == 4) ? 1 : 0);

    // Reset during the ISSUE cycle of a load.
    set_req(0, 0, 2'd2, 0, 7'h08, 32'd0);
    r_req[0] = 1'b1;
    got_gnt[0] = 1'b0;
    n = 0;
    while (!got_gnt[0] && n < 20) begin step(); n++; end
    r_req[0] = 1'b0;
    got_gnt[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    do_op(0, 0, 2'd2, 0, 7'h08, 32'd0);
    cmp("post_rst_lw", last_rdata, 32'h80ADBEEF);

    // Randomized two-port traffic; a request is held until granted.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(r_req[p] && !got_gnt[p])) begin
          if ($urandom_range(0, 1) == 1) begin rand_req(p); r_req[p] = 1'b1; end
          else r_req[p] = 1'b0;
        end
        got_gnt[p] = 1'b0;
      end
      step();
    end
    r_req = 2'b00;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dmem_lsu_arb.md
Name: dmem_lsu_arb

Overview:
- Load/store sequencer and two-port arbiter in front of the 32-word byte-masked data memory.
- Port 0 is the core LSU; port 1 is the debug/loader port.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word address, byte mask and lane-aligned write data, then sign- or zero-extends read data.
- Owns the memory's single access slot: one request in flight at a time.

Parameters:
- ADDR_W, 7, byte-address width; word index is addr[6:2], giving 32 words.
- STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 is waiting before port 1 is forced.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- p0_req  in  1  port 0 request
- p0_we  in  1  1 = store, 0 = load
- p0_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- p0_uns  in  1  zero-extend loads
- p0_addr  in  ADDR_W  byte address
- p0_wdata  in  32  store data, right-justified
- p0_gnt  out  1  request accepted this cycle
- p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata, p1_gnt: same meaning, port 1
- resp_valid  out  1  response strobe, one cycle
- resp_port  out  1  port that owns the response
- resp_err  out  1  misaligned or illegal size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_wren  out  1  to memory wren
- mem_is_load  out  1  to memory is_load
- mem_mask  out  4  to memory mask_buffer
- mem_r_addr  out  5  read word address
- mem_w_addr  out  5  write word address
- mem_w_data  out  32  lane-aligned write data
- mem_r_data  in  32  memory registered read data

Behaviour:
- Reset, asynchronous:
  - State is IDLE.
  - All outputs are 0.
  - Starvation counter is 0.
  - Last-owner register is 0.
- States and transitions:
  - IDLE -> ISSUE on grant of a legal request.
  - IDLE -> ERR on grant of an illegal request.
  - ISSUE -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
  - ERR -> IDLE unconditionally.
- Grants:
  - Combinational, asserted only in IDLE, at most one port per cycle.
  - Port 0 wins by default.
  - Port 1 wins if port 0 is idle, or if the starvation counter equals STARVE_LIMIT.
  - The starvation counter increments on each port-0 grant while p1_req=1.
  - It clears on any port-1 grant, or when p1_req=0 in IDLE.
  - The counter saturates at STARVE_LIMIT.
- Capture: on a grant, latch we, size, uns, addr, wdata and port into request registers. The requester may drop or change its signals on the next cycle.
- Legality:
  - size=11 is an error.
  - Half access requires addr[0]=0.
  - Word access requires addr[1:0]=00.
  - An illegal request gets no memory access.
- ISSUE, exactly one cycle:
  - Both mem_r_addr and mem_w_addr equal addr[6:2].
  - Store: mem_wren=1, mem_is_load=0.
    - Byte: mask = 1<<addr[1:0]; wdata[7:0] is replicated to all four lanes.
    - Half: mask = 0011 or 1100 by addr[1]; wdata[15:0] is replicated to both halves.
    - Word: mask = 1111.
  - Load: mem_is_load=1, mem_wren=0, mask=0000.
  - In every other state all mem_* control and mask outputs are 0. Address and data outputs may hold.
- RESP (two cycles after grant):
  - resp_valid=1 and resp_port is the owner.
  - For loads, select the lane from mem_r_data using the latched addr.
    - Byte: bits [8*addr[1:0]+7 : 8*addr[1:0]].
    - Half: lower or upper 16 bits by addr[1].
  - Extend to 32 bits: sign-extend if uns=0, zero-extend if uns=1.
- ERR (one cycle after grant): resp_valid=1, resp_err=1, resp_rdata=0.
- Throughput: one legal access per 3 cycles; one illegal request per 2 cycles.
- Reset mid-operation: the transaction is dropped with no response. A store already clocked in ISSUE stays in memory.
- Simultaneous requests in IDLE: exactly one gnt is asserted. The loser keeps req high and is served later; it is never dropped.

Test Plan:
- Store then load:
  - P0 SW addr=0x08 data=0xDEADBEEF -> ISSUE shows wren=1, mask=1111, w_addr=2.
  - Then P0 LW 0x08 -> resp_rdata=0xDEADBEEF, two cycles after grant.
- Byte lanes and extension:
  - SB addr=0x0B data=0x80 -> mask=1000.
  - LB 0x0B -> 0xFFFFFF80.
  - LBU 0x0B -> 0x00000080.
  - LH 0x0A with word 0x80xx_xxxx -> sign-extended upper half.
- Misalignment:
  - LW addr=0x06 -> resp_err=1 one cycle after grant, no mem_is_load or mem_wren pulse.
  - size=11 -> same error response.
- Arbitration and starvation, with STARVE_LIMIT=4 and both ports requesting continuously:
  - Grant sequence is P0,P0,P0,P0,P1, then repeats.
  - resp_port matches each grant.
- Reset mid-op: assert rst during ISSUE of a load -> no resp_valid, all outputs 0 immediately, next request serviced normally.
- Half store: SH addr=0x12 data=0x1234 -> mask=1100, w_data=0x12341234; LHU 0x12 -> 0x00001234.
